// File: rtl/openhw_flopen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : openhw_flopen_pipe
// Brief    : DEPTH-stage valid/ready register pipeline with enabled stages,
//            bubble collapsing, synchronous flush and an occupancy count.
//            Define OPENHW_FLOPEN_PIPE_CLEAR_EN to reset/clear data registers.
// Revision : 1.0 - initial release
// ============================================================================
module openhw_flopen_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] stage_ready;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             in_xfer;
    logic             out_xfer;

    // Unrolled ready chain: a stage can load if any stage from it to the
    // output is empty, or the output is draining this cycle.
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_ready
        assign stage_ready[gi] = out_ready | ~(&valid_q[DEPTH-1:gi]);
    end

    assign in_ready  = stage_ready[0] & ~flush;
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end
        if (flush) begin
            valid_d = '0;
`ifdef OPENHW_FLOPEN_PIPE_CLEAR_EN
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
            end
`endif
        end else begin
            if (stage_ready[0]) begin
                valid_d[0] = in_valid;
`ifdef OPENHW_FLOPEN_PIPE_CLEAR_EN
                data_d[0]  = in_valid ? in_data : '0;
`else
                data_d[0]  = in_data;
`endif
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (stage_ready[i]) begin
                    valid_d[i] = valid_q[i-1];
                    data_d[i]  = data_q[i-1];
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

`ifdef OPENHW_FLOPEN_PIPE_CLEAR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            data_q <= data_d;
        end
    end
`else
    // Payload carries no reset; validity alone qualifies it.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_openhw_flopen_pipe.sv
`default_nettype none
// Bench for openhw_flopen_pipe: DEPTH 1/2/3 instances share one stimulus
// stream and are each compared against a position-list reference model.
module tb_openhw_flopen_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       rdy1, rdy2, rdy3;
    logic       ov1, ov2, ov3;
    logic [7:0] od1, od2, od3;
    logic [0:0] cnt1;
    logic [1:0] cnt2, cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: entries oldest-first, each with a stage position and payload.
    int         mpos [3][4];
    logic [7:0] mdat [3][4];
    int         mcnt [3];
    int         newp [3][4];
    logic       erdy [3];
    logic       eout [3];

    always #5 clk = ~clk;

    openhw_flopen_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy1), .out_valid(ov1), .out_data(od1),
        .out_ready(out_ready), .count(cnt1));
    openhw_flopen_pipe #(.WIDTH(8), .DEPTH(2)) u_d2 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy2), .out_valid(ov2), .out_data(od2),
        .out_ready(out_ready), .count(cnt2));
    openhw_flopen_pipe #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy3), .out_valid(ov3), .out_data(od3),
        .out_ready(out_ready), .count(cnt3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int k, input int sel);
        logic [31:0] r;
        r = '0;
        case (k)
            0: case (sel) 0: r = {31'd0, rdy1}; 1: r = {31'd0, ov1}; 2: r = {24'd0, od1}; default: r = {31'd0, cnt1}; endcase
            1: case (sel) 0: r = {31'd0, rdy2}; 1: r = {31'd0, ov2}; 2: r = {24'd0, od2}; default: r = {30'd0, cnt2}; endcase
            default: case (sel) 0: r = {31'd0, rdy3}; 1: r = {31'd0, ov3}; 2: r = {24'd0, od3}; default: r = {30'd0, cnt3}; endcase
        endcase
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
    endtask

    // Work out where every held entry sits after the coming edge.
    task automatic model_eval();
        for (int k = 0; k < 3; k++) begin
            int d;
            d = k + 1;
            for (int j = 0; j < mcnt[k]; j++) begin
                if (j == 0) begin
                    if (mpos[k][0] == d - 1) newp[k][0] = out_ready ? d : d - 1;
                    else                      newp[k][0] = mpos[k][0] + 1;
                end else begin
                    newp[k][j] = (mpos[k][j] + 1 == newp[k][j-1]) ? mpos[k][j] : mpos[k][j] + 1;
                end
            end
            erdy[k] = !flush;
            for (int j = 0; j < mcnt[k]; j++) if (newp[k][j] == 0) erdy[k] = 1'b0;
            eout[k] = out_ready && mcnt[k] > 0 && mpos[k][0] == d - 1;
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 3; k++) begin
            logic ev;
            ev = mcnt[k] > 0 && mpos[k][0] == k;
            check($sformatf("d%0d_in_ready", k+1),  obs(k, 0), {31'd0, erdy[k]});
            check($sformatf("d%0d_out_valid", k+1), obs(k, 1), {31'd0, ev});
            check($sformatf("d%0d_count", k+1),     obs(k, 3), mcnt[k]);
            if (ev) check($sformatf("d%0d_out_data", k+1), obs(k, 2), {24'd0, mdat[k][0]});
`ifdef OPENHW_FLOPEN_PIPE_CLEAR_EN
            else    check($sformatf("d%0d_idle_data", k+1), obs(k, 2), 32'd0);
`endif
        end
    endtask

    task automatic model_commit(input logic iv, input logic [7:0] id, input logic fl);
        for (int k = 0; k < 3; k++) begin
            int         tpos [4];
            logic [7:0] tdat [4];
            int         n;
            n = 0;
            if (!fl) begin
                for (int j = (eout[k] ? 1 : 0); j < mcnt[k]; j++) begin
                    tpos[n] = newp[k][j];
                    tdat[n] = mdat[k][j];
                    n++;
                end
                if (iv && erdy[k]) begin
                    tpos[n] = 0;
                    tdat[n] = id;
                    n++;
                end
                for (int j = 0; j < n; j++) begin
                    mpos[k][j] = tpos[j];
                    mdat[k][j] = tdat[j];
                end
            end
            mcnt[k] = n;
        end
    endtask

    // One clock: drive, check against the model, take the edge, advance model.
    task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        model_eval();
        compare();
        @(posedge clk);
        model_commit(iv, id, fl);
        #1;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        check("rst_d1_out_valid", {31'd0, ov1}, 32'd0);
        check("rst_d2_out_valid", {31'd0, ov2}, 32'd0);
        check("rst_d3_out_valid", {31'd0, ov3}, 32'd0);
        check("rst_d1_count", {31'd0, cnt1}, 32'd0);
        check("rst_d2_count", {30'd0, cnt2}, 32'd0);
        check("rst_d3_count", {30'd0, cnt3}, 32'd0);
`ifdef OPENHW_FLOPEN_PIPE_CLEAR_EN
        check("rst_d2_data", {24'd0, od2}, 32'd0);
`endif
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();
        check("post_rst_in_ready", {31'd0, rdy2}, 32'd1);

        // Streaming, DEPTH=2
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        cycle(1'b1, 8'h22, 1'b1, 1'b0);
        check("stream_v0", {31'd0, ov2}, 32'd1);
        check("stream_d0", {24'd0, od2}, 32'h11);
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        check("stream_d1", {24'd0, od2}, 32'h22);
        check("stream_cnt", {30'd0, cnt2}, 32'd2);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_d2", {24'd0, od2}, 32'h33);

        // Full and stall, DEPTH=2
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0);
        check("full_cnt", {30'd0, cnt2}, 32'd2);
        check("full_in_ready", {31'd0, rdy2}, 32'd0);
        cycle(1'b1, 8'hA3, 1'b0, 1'b0);
        check("stall_hold", {24'd0, od2}, 32'hA1);
        cycle(1'b1, 8'hA3, 1'b1, 1'b0);
        check("drain_a2", {24'd0, od2}, 32'hA2);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_a3", {24'd0, od2}, 32'hA3);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_empty", {31'd0, ov2}, 32'd0);

        // Bubble collapse, DEPTH=3
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("bubble_head", {24'd0, od3}, 32'h5A);
        cycle(1'b1, 8'h5B, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("bubble_cnt", {30'd0, cnt3}, 32'd2);
        cycle(1'b1, 8'h5C, 1'b0, 1'b0);
        check("bubble_full", {31'd0, rdy3}, 32'd0);

        // Flush alongside an output transfer, DEPTH=2
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        check("fl_pre_data", {24'd0, od2}, 32'h01);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("fl_out_valid", {31'd0, ov2}, 32'd0);
        check("fl_count", {30'd0, cnt2}, 32'd0);
        check("fl_in_ready", {31'd0, rdy2}, 32'd1);

        // Push and pop together while full, DEPTH=1
        cycle(1'b1, 8'h7E, 1'b0, 1'b0);
        check("d1_hold", {24'd0, od1}, 32'h7E);
        check("d1_full", {31'd0, rdy1}, 32'd0);
        cycle(1'b1, 8'h7F, 1'b1, 1'b0);
        check("d1_swap_data", {24'd0, od1}, 32'h7F);
        check("d1_swap_cnt", {31'd0, cnt1}, 32'd1);

        // Reset in the middle of traffic
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0);
        check("mid_cnt", {30'd0, cnt2}, 32'd2);
        reset_pulse();
        check("mid_in_ready", {31'd0, rdy2}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) reset_pulse();
            cycle($urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/openhw_flopen_pipe.md
OPENHW_FLOPEN_PIPE -- requirements
Module: openhw_flopen_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per entry (WIDTH >= 1).
REQ-002 SHALL have parameter DEPTH, default 2, meaning number of register stages (DEPTH >= 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port in_ready  output  1  pipeline accepts in_data this cycle.
REQ-009 SHALL have port out_valid  output  1  stage DEPTH-1 holds an entry.
REQ-010 SHALL have port out_data  output  WIDTH  payload of stage DEPTH-1.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries held.

Function
REQ-013 SHALL implement DEPTH stages 0..DEPTH-1, each holding a WIDTH-bit data register and a valid bit; stage 0 faces input, stage DEPTH-1 drives out_data/out_valid directly from registers.
REQ-014 SHALL define stage ready: ready[DEPTH-1] = ~valid[DEPTH-1] | out_ready; ready[i] = ~valid[i] | ready[i+1] for i < DEPTH-1 (combinational chain, bubble-collapsing).
REQ-015 SHALL drive in_ready = ready[0] & ~flush.
REQ-016 SHALL load stage i (data and valid) only when ready[i] is 1; stage 0 loads in_data with valid = in_valid & ~flush; stage i>0 loads stage i-1 data and valid[i-1].
REQ-017 SHALL hold data and valid of any stage whose ready is 0 (enabled-register behaviour, no data loss under stall).
REQ-018 SHALL complete an input transfer iff in_valid & in_ready, and an output transfer iff out_valid & out_ready.
REQ-019 SHALL give latency DEPTH cycles from input transfer to out_valid with out_ready held 1 and an empty pipeline; throughput one entry per cycle.
REQ-020 SHALL, with out_ready held 0, accept exactly DEPTH entries then drive in_ready 0 (full).
REQ-021 SHALL, on flush=1 at a rising edge, clear every valid bit; an output transfer in that same cycle completes normally; no input transfer occurs in that cycle.
REQ-022 SHALL keep out_valid and in_ready independent of flush except as stated in REQ-015.
REQ-023 SHALL update count each cycle: +1 on input transfer, -1 on output transfer, unchanged on both or neither, 0 after flush; count SHALL always equal the number of set valid bits.
REQ-024 SHALL never change out_data while out_valid=1 and out_ready=0.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force all valid bits 0, count 0, out_valid 0, independent of clk.
REQ-026 SHALL drive in_ready 1 in the first cycle after reset_n deasserts (when flush=0).
REQ-027 SHALL discard in-flight entries when reset asserts mid-operation; no partial transfer survives.

Configuration
REQ-028 SHALL honour macro OPENHW_FLOPEN_PIPE_CLEAR_EN: when defined, data registers reset to 0 under reset_n=0 and clear to 0 on flush, and out_data reads 0 whenever out_valid=0.
REQ-029 SHALL, without OPENHW_FLOPEN_PIPE_CLEAR_EN, leave data registers unreset (no reset term on data) and unchanged by flush; out_data is don't-care when out_valid=0.

Verification
REQ-030 SHALL cover streaming: DEPTH=2, out_ready=1, in_data 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles 2,3,4, count 2 at steady state.
REQ-031 SHALL cover full/stall: DEPTH=2, out_ready=0, push 0xA1,0xA2,0xA3 -> in_ready 0 after two transfers, count 2, 0xA3 held upstream; release out_ready -> outputs 0xA1,0xA2,0xA3 in order.
REQ-032 SHALL cover bubble collapse: DEPTH=3, one entry 0x5A stalled at output, push 0x5B -> it advances to stage 1 within 2 cycles, count 2.
REQ-033 SHALL cover flush with simultaneous output transfer: DEPTH=2 full (0x01,0x02), flush=1 and out_ready=1 same cycle -> 0x01 consumed, next cycle out_valid 0, count 0, in_ready 1.
REQ-034 SHALL cover mid-operation reset: count 2, reset_n pulsed low between clock edges -> out_valid and count 0 immediately; with OPENHW_FLOPEN_PIPE_CLEAR_EN defined out_data 0x00.
REQ-035 SHALL cover simultaneous push and pop when full: DEPTH=1 holding 0x7E, in_valid=1 with 0x7F, out_ready=1 -> both transfers complete, count stays 1, out_data 0x7F next cycle.
